// File: rtl/pulse_seq_engine.sv
// pulse_seq_engine: table-driven pulse sequencer.
// A table of NSTEP steps (duration + NCH-bit output pattern) is written from the
// 16-bit config bus while idle. A start request plays the table from step 0
// with one optional loop-back region, then flags completion with a one-cycle
// done pulse. Abort returns to idle at once without a done pulse.
module pulse_seq_engine #(
    parameter int NCH   = 16,
    parameter int TW    = 22,
    parameter int NSTEP = 16,
    parameter int AW    = 4,
    parameter int RW    = 16
) (
    input  logic           clk_sys,
    input  logic           scalerst,
    input  logic           cfg_we,
    input  logic [2:0]     cfg_sel,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [15:0]    cfg_data,
    input  logic           start,
    input  logic           abort,
    output logic [NCH-1:0] ch_out,
    output logic [AW-1:0]  step_idx,
    output logic [RW-1:0]  rep_idx,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_DUR_LO  = 3'd0;
    localparam logic [2:0] SEL_DUR_HI  = 3'd1;
    localparam logic [2:0] SEL_PAT_LO  = 3'd2;
    localparam logic [2:0] SEL_PAT_HI  = 3'd3;
    localparam logic [2:0] SEL_LOOP    = 3'd4;
    localparam logic [2:0] SEL_REPEAT  = 3'd5;
    localparam logic [2:0] SEL_LAST    = 3'd6;

    state_t r_state;
    state_t w_state_nxt;

    // Step table and run globals
    logic [TW-1:0]  r_dur [NSTEP];
    logic [NCH-1:0] r_pat [NSTEP];
    logic [AW-1:0]  r_loop_start;
    logic [AW-1:0]  r_loop_end;
    logic [RW-1:0]  r_repeat;
    logic [AW-1:0]  r_last_step;

    // Run datapath
    logic [AW-1:0]  r_step_idx;
    logic [RW-1:0]  r_rep_idx;
    logic [TW-1:0]  r_cnt;

    logic           w_cfg_en;
    logic [TW-1:0]  w_dur_wr;
    logic [NCH-1:0] w_pat_wr;
    logic [RW-1:0]  w_rep_lim;
    logic [RW:0]    w_rep_inc;
    logic           w_loop_en;
    logic           w_loop_back;
    logic           w_is_last;
    logic           w_step_end;
    logic           w_advance;
    logic [AW-1:0]  w_next_step;
    logic [AW-1:0]  w_load_step;
    logic [TW-1:0]  w_load_dur;
    logic [TW-1:0]  w_load_cnt;

    // Table and globals only change while idle, so a run sees a frozen program.
    assign w_cfg_en = cfg_we && (r_state == ST_IDLE);

    // Merge the 16-bit config word into the addressed duration/pattern entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_dur_wr = r_dur[cfg_addr];
        w_pat_wr = r_pat[cfg_addr];
        for (int b = 0; b < TW; b++) begin
            if ((b < 16 && cfg_sel == SEL_DUR_LO) || (b >= 16 && cfg_sel == SEL_DUR_HI))
                w_dur_wr[b] = cfg_data[b[3:0]];
        end
        for (int b = 0; b < NCH; b++) begin
            if ((b < 16 && cfg_sel == SEL_PAT_LO) || (b >= 16 && cfg_sel == SEL_PAT_HI))
                w_pat_wr[b] = cfg_data[b[3:0]];
        end
    end

    // Step table write port.
    // NOTE: the table is plain storage with no reset, so it can map onto RAM; reset leaves it intact.
    always_ff @(posedge clk_sys) begin
        if (w_cfg_en) begin
            if (cfg_sel == SEL_DUR_LO || cfg_sel == SEL_DUR_HI)
                r_dur[cfg_addr] <= w_dur_wr;
            if (cfg_sel == SEL_PAT_LO || cfg_sel == SEL_PAT_HI)
                r_pat[cfg_addr] <= w_pat_wr;
        end
    end

    // Global run parameters; cleared by reset, written only while idle.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (scalerst) begin
            r_loop_start <= '0;
            r_loop_end   <= '0;
            r_repeat     <= '0;
            r_last_step  <= '0;
        end else if (w_cfg_en) begin
            case (cfg_sel)
                SEL_LOOP: begin
                    r_loop_end   <= cfg_data[2*AW-1:AW];
                    r_loop_start <= cfg_data[AW-1:0];
                end
                SEL_REPEAT: r_repeat    <= cfg_data[RW-1:0];
                SEL_LAST:   r_last_step <= cfg_data[AW-1:0];
                default: ;
            endcase
        end
    end

    // Step sequencing decisions for the current cycle.
    always_comb begin
        w_rep_lim   = (r_repeat == '0) ? RW'(1) : r_repeat;
        w_rep_inc   = {1'b0, r_rep_idx} + (RW+1)'(1);
        // A backwards or out-of-program loop region disables looping entirely.
        w_loop_en   = (r_loop_end >= r_loop_start) && (r_loop_end <= r_last_step);
        // rep_idx+1 stays below the limit (at most 2^RW-1), so rep_idx never wraps.
        w_loop_back = w_loop_en && (r_step_idx == r_loop_end) && (w_rep_inc < {1'b0, w_rep_lim});
        // The final table entry always ends the run, even if last_step points past it.
        w_is_last   = (r_step_idx == r_last_step) || (r_step_idx == AW'(NSTEP-1));
        w_step_end  = (r_cnt == TW'(1));
        w_advance   = w_step_end && (w_loop_back || !w_is_last);
        w_next_step = w_loop_back ? r_loop_start : r_step_idx + AW'(1);
        w_load_step = (r_state == ST_IDLE) ? '0 : w_next_step;
        w_load_dur  = r_dur[w_load_step];
        // A zero duration still occupies one cycle.
        w_load_cnt  = (w_load_dur == '0) ? TW'(1) : w_load_dur;
    end

    // FSM state register.
    always_ff @(posedge clk_sys) begin
        if (scalerst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state; abort wins over start and over step advance.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start && !abort) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)
                    w_state_nxt = ST_IDLE;
                else if (w_step_end && !w_loop_back && w_is_last)
                    w_state_nxt = ST_FIN;
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Run datapath: step index, loop counter and per-step cycle counter.
    always_ff @(posedge clk_sys) begin
        if (scalerst) begin
            r_step_idx <= '0;
            r_rep_idx  <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_step_idx <= '0;
                        r_rep_idx  <= '0;
                        r_cnt      <= w_load_cnt;
                    end
                end
                ST_RUN: begin
                    if (!abort) begin
                        if (w_advance) begin
                            r_step_idx <= w_next_step;
                            r_cnt      <= w_load_cnt;
                            if (w_loop_back)
                                r_rep_idx <= w_rep_inc[RW-1:0];
                        end else if (!w_step_end) begin
                            r_cnt <= r_cnt - TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM outputs: the pattern of the active step while running, quiet otherwise.
    always_comb begin
        ch_out = '0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_RUN: begin
                ch_out = r_pat[r_step_idx];
                busy   = 1'b1;
            end
            ST_FIN:  done = 1'b1;
            default: ;
        endcase
    end

    assign step_idx = r_step_idx;
    assign rep_idx  = r_rep_idx;

endmodule

// File: tb/tb_pulse_seq_engine.sv
// Directed testbench for pulse_seq_engine: expected traces are hand-derived
// from the step table each scenario programs.
module tb_pulse_seq_engine;

    localparam int NCH   = 16;
    localparam int TW    = 22;
    localparam int NSTEP = 16;
    localparam int AW    = 4;
    localparam int RW    = 16;

    logic           clk_sys = 1'b0;
    logic           scalerst;
    logic           cfg_we;
    logic [2:0]     cfg_sel;
    logic [AW-1:0]  cfg_addr;
    logic [15:0]    cfg_data;
    logic           start;
    logic           abort;
    logic [NCH-1:0] ch_out;
    logic [AW-1:0]  step_idx;
    logic [RW-1:0]  rep_idx;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;

    pulse_seq_engine #(
        .NCH(NCH), .TW(TW), .NSTEP(NSTEP), .AW(AW), .RW(RW)
    ) dut (
        .clk_sys  (clk_sys),
        .scalerst (scalerst),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .abort    (abort),
        .ch_out   (ch_out),
        .step_idx (step_idx),
        .rep_idx  (rep_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_sys = ~clk_sys;

    // All tasks are entered and left at a falling edge: outputs are sampled
    // there and inputs driven there, half a period away from the active edge.
    task automatic cfg_write(input logic [2:0] sel, input logic [AW-1:0] addr, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk_sys);
        cfg_we   = 1'b0;
    endtask

    task automatic set_step(input logic [AW-1:0] addr, input logic [TW-1:0] dur, input logic [15:0] pat);
        cfg_write(3'd0, addr, dur[15:0]);
        cfg_write(3'd1, addr, {10'b0, dur[21:16]});
        cfg_write(3'd2, addr, pat);
    endtask

    // One-cycle start pulse; on return the outputs show the first run cycle.
    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic test_reset;
        scalerst = 1'b1;
        cfg_we   = 1'b0;
        cfg_sel  = 3'd0;
        cfg_addr = '0;
        cfg_data = '0;
        start    = 1'b0;
        abort    = 1'b0;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (ch_out !== 16'h0 || step_idx !== 4'h0 || rep_idx !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: ch_out=%h step_idx=%0d rep_idx=%0d busy=%b done=%b, required all zero",
                     ch_out, step_idx, rep_idx, busy, done);
        end
        scalerst = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_basic;
        logic [15:0] exp_ch;
        logic [3:0]  exp_step;
        set_step(4'd0, 22'd3, 16'h0001);
        set_step(4'd1, 22'd5, 16'h0002);
        cfg_write(3'd6, 4'd0, 16'd1);
        pulse_start;
        for (int i = 0; i < 8; i++) begin
            exp_ch   = (i < 3) ? 16'h0001 : 16'h0002;
            exp_step = (i < 3) ? 4'd0 : 4'd1;
            checks++;
            if (ch_out !== exp_ch || step_idx !== exp_step || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_run cycle %0d: ch_out=%h step_idx=%0d busy=%b done=%b, required ch_out=%h step_idx=%0d busy=1 done=0",
                         i, ch_out, step_idx, busy, done, exp_ch, exp_step);
            end
            @(negedge clk_sys);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ch_out !== 16'h0) begin
            errors++;
            $display("FAIL basic_fin: done=%b busy=%b ch_out=%h, required done=1 busy=0 ch_out=0000", done, busy, ch_out);
        end
        @(negedge clk_sys);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || ch_out !== 16'h0) begin
            errors++;
            $display("FAIL basic_idle: done=%b busy=%b ch_out=%h, required done=0 busy=0 ch_out=0000", done, busy, ch_out);
        end
    endtask

    task automatic test_loop;
        int          seq  [8] = '{0, 1, 2, 1, 2, 1, 2, 3};
        int          reps [8] = '{0, 0, 0, 1, 1, 2, 2, 2};
        logic [15:0] exp_ch;
        for (int s = 0; s < 4; s++)
            set_step(4'(s), 22'd2, 16'(1) << s);
        cfg_write(3'd4, 4'd0, 16'h0021);   // loop_end=2, loop_start=1
        cfg_write(3'd5, 4'd0, 16'd3);
        cfg_write(3'd6, 4'd0, 16'd3);
        pulse_start;
        for (int i = 0; i < 16; i++) begin
            exp_ch = 16'(1) << seq[i/2];
            checks++;
            if (ch_out !== exp_ch || step_idx !== 4'(seq[i/2]) || rep_idx !== 16'(reps[i/2]) || busy !== 1'b1) begin
                errors++;
                $display("FAIL loop_run cycle %0d: ch_out=%h step_idx=%0d rep_idx=%0d busy=%b, required ch_out=%h step_idx=%0d rep_idx=%0d busy=1",
                         i, ch_out, step_idx, rep_idx, busy, exp_ch, seq[i/2], reps[i/2]);
            end
            @(negedge clk_sys);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rep_idx !== 16'd2) begin
            errors++;
            $display("FAIL loop_fin: done=%b busy=%b rep_idx=%0d, required done=1 busy=0 rep_idx=2", done, busy, rep_idx);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_zero_dur;
        // Loop region 1..2 now lies beyond last_step=0, so it is disabled.
        set_step(4'd0, 22'd0, 16'hAAAA);
        cfg_write(3'd6, 4'd0, 16'd0);
        pulse_start;
        checks++;
        if (ch_out !== 16'hAAAA || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_dur_run: ch_out=%h busy=%b, required ch_out=aaaa busy=1", ch_out, busy);
        end
        @(negedge clk_sys);
        checks++;
        if (done !== 1'b1 || ch_out !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_dur_fin: done=%b ch_out=%h busy=%b, required done=1 ch_out=0000 busy=0", done, ch_out, busy);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_abort;
        int seen_done;
        set_step(4'd0, 22'd10, 16'h0F0F);
        pulse_start;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (ch_out !== 16'h0F0F || busy !== 1'b1) begin
                errors++;
                $display("FAIL abort_pre cycle %0d: ch_out=%h busy=%b, required ch_out=0f0f busy=1", i, ch_out, busy);
            end
            if (i == 4) abort = 1'b1;
            @(negedge clk_sys);
        end
        abort = 1'b0;
        checks++;
        if (ch_out !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: ch_out=%h busy=%b done=%b, required ch_out=0000 busy=0 done=0", ch_out, busy, done);
        end
        seen_done = 0;
        repeat (12) begin
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
            @(negedge clk_sys);
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d cycles with done or busy after abort, required 0", seen_done);
        end
        pulse_start;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ch_out !== 16'h0F0F || step_idx !== 4'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL abort_replay cycle %0d: ch_out=%h step_idx=%0d busy=%b, required ch_out=0f0f step_idx=0 busy=1",
                         i, ch_out, step_idx, busy);
            end
            @(negedge clk_sys);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_replay_fin: done=%b, required 1", done);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_cfg_during_run;
        logic [15:0] exp_ch;
        set_step(4'd0, 22'd3, 16'h0001);
        set_step(4'd1, 22'd5, 16'h0002);
        cfg_write(3'd6, 4'd0, 16'd1);
        start = 1'b1;                      // held high through the whole run
        @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            exp_ch = (i < 3) ? 16'h0001 : 16'h0002;
            checks++;
            if (ch_out !== exp_ch || busy !== 1'b1) begin
                errors++;
                $display("FAIL cfg_run cycle %0d: ch_out=%h busy=%b, required ch_out=%h busy=1", i, ch_out, busy, exp_ch);
            end
            if (i == 1) begin
                cfg_we   = 1'b1;
                cfg_sel  = 3'd2;
                cfg_addr = 4'd0;
                cfg_data = 16'hFFFF;
            end
            if (i == 2) cfg_we = 1'b0;
            @(negedge clk_sys);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_fin: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        start = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ch_out !== 16'h0) begin
            errors++;
            $display("FAIL cfg_single_run: busy=%b done=%b ch_out=%h, required busy=0 done=0 ch_out=0000", busy, done, ch_out);
        end
        pulse_start;
        checks++;
        if (ch_out !== 16'h0001) begin
            errors++;
            $display("FAIL cfg_rerun_pattern: ch_out=%h, required 0001", ch_out);
        end
        repeat (8) @(negedge clk_sys);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL cfg_rerun_fin: done=%b, required 1", done);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_long_dur;
        int bad;
        cfg_write(3'd6, 4'd0, 16'd1);
        // Duration carried only in the upper field: 0x3F0000 cycles.
        set_step(4'd0, 22'h3F0000, 16'h8001);
        pulse_start;
        bad = 0;
        repeat (500) begin
            if (ch_out !== 16'h8001 || busy !== 1'b1 || step_idx !== 4'd0) bad++;
            @(negedge clk_sys);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL long_upper_hold: %0d of 500 cycles off, required 0", bad);
        end
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || ch_out !== 16'h0) begin
            errors++;
            $display("FAIL long_upper_abort: busy=%b ch_out=%h, required busy=0 ch_out=0000", busy, ch_out);
        end
        set_step(4'd0, 22'h3FFFFF, 16'h8001);
        pulse_start;
        bad = 0;
        repeat (1500) begin
            if (ch_out !== 16'h8001 || busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk_sys);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL long_max_hold: %0d of 1500 cycles off, required 0", bad);
        end
        scalerst = 1'b1;
        @(negedge clk_sys);
        scalerst = 1'b0;
        checks++;
        if (ch_out !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 4'd0 || rep_idx !== 16'd0) begin
            errors++;
            $display("FAIL long_midrun_reset: ch_out=%h busy=%b done=%b step_idx=%0d rep_idx=%0d, required all zero",
                     ch_out, busy, done, step_idx, rep_idx);
        end
        // Reset cleared last_step (was 1): a new run must stop after step 0.
        set_step(4'd0, 22'd2, 16'h0003);
        pulse_start;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ch_out !== 16'h0003 || busy !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_run cycle %0d: ch_out=%h busy=%b, required ch_out=0003 busy=1", i, ch_out, busy);
            end
            @(negedge clk_sys);
        end
        checks++;
        if (done !== 1'b1 || ch_out !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_globals: done=%b ch_out=%h, required done=1 ch_out=0000", done, ch_out);
        end
        @(negedge clk_sys);
    endtask

    initial begin
        @(negedge clk_sys);
        test_reset;
        test_basic;
        test_loop;
        test_zero_dur;
        test_abort;
        test_cfg_during_run;
        test_long_dur;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pulse_seq_engine.md
Name: pulse_seq_engine

Overview:
- Parametrised successor to the fixed NMR scale-state sequencer and down-counting timer pair.
- Holds a programmable table of NSTEP steps. Each step has a duration, an NCH-bit output pattern and optional loop-back, so CPMG-style echo trains run without firmware per state.
- Configured from the DSP-side bus (datain/loadchoice style), started by a start strobe, and reports completion with a one-cycle done pulse.

Parameters:
- NCH, 16, number of pulse/control output channels
- TW, 22, step duration counter width in clk_sys cycles
- NSTEP, 16, number of table entries (power of 2)
- AW, 4, step address width (log2 NSTEP)
- RW, 16, loop repeat count width

Ports:
- clk_sys  in  1  system clock
- scalerst  in  1  synchronous active-high reset
- cfg_we  in  1  config write strobe, one word per cycle
- cfg_sel  in  3  field select: 0 dur[15:0], 1 dur[TW-1:16], 2 pattern[15:0], 3 pattern[NCH-1:16] (ignored if NCH<=16), 4 global {loop_end, loop_start} (bits [2AW-1:AW], [AW-1:0]), 5 global repeat count, 6 global last_step
- cfg_addr  in  AW  step index for sel 0-3
- cfg_data  in  16  write data
- start  in  1  run request (level or pulse; acted on only in IDLE)
- abort  in  1  stop immediately
- ch_out  out  NCH  current step pattern
- step_idx  out  AW  currently active step
- rep_idx  out  RW  completed loop iterations in this run
- busy  out  1  high while RUN
- done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset (scalerst=1 on a clk_sys edge):
  - ch_out=0, step_idx=0, rep_idx=0, busy=0, done=0, FSM=IDLE.
  - Globals clear: loop_start=0, loop_end=0, repeat=0, last_step=0.
  - Table contents are not cleared.
- Config:
  - With cfg_we=1 in IDLE, the selected field is written at that edge.
  - cfg_we while busy is ignored. Table and globals are stable during a run.
  - Undefined cfg_sel (7) is ignored.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - ch_out=0, busy=0.
  - start=1 and abort=0: on the next edge FSM=RUN, step_idx=0, ch_out=pattern[0], cnt=max(dur[0],1), rep_idx=0, busy=1.
- RUN:
  - Each cycle cnt decrements. Step k therefore drives pattern[k] for exactly max(dur[k],1) cycles.
  - When cnt==1, the next edge advances by priority:
    - (a) step_idx==loop_end and rep_idx+1<max(repeat,1): step_idx<=loop_start, rep_idx<=rep_idx+1.
    - (b) step_idx==last_step: FSM=FIN.
    - (c) otherwise: step_idx<=step_idx+1.
  - On advance, ch_out and cnt load from the new step in the same edge. There are no gap cycles between steps.
  - If step_idx reaches NSTEP-1 without matching last_step, treat it as last_step.
  - loop_end<loop_start or loop_end>last_step: loop disabled; rule (a) never fires.
  - Loop body runs max(repeat,1) times in total. repeat=0 or 1 means a single pass.
- FIN (one cycle): ch_out=0, busy=0, done=1, rep_idx holds its final value. Next edge → IDLE, done=0.
- abort=1 in any state: next edge → IDLE, ch_out=0, busy=0, no done pulse. abort has priority over start and over step advance in the same cycle.
- start while RUN/FIN is ignored. No queuing.
- Reset mid-run: same as reset. Outputs clear next edge.
- Duration arithmetic:
  - dur=0 is treated as 1.
  - Maximum step length is 2^TW-1 cycles.
  - rep_idx saturates at 2^RW-1; it cannot exceed repeat-1 by construction.
- Total run length: sum of step cycles + 1 FIN cycle. Latency from start sampled to ch_out valid is 1 cycle.

Test Plan:
- Reset, load step0 dur=3 pat=0x0001, step1 dur=5 pat=0x0002, last_step=1, pulse start → ch_out 0x0001 for 3 cycles, 0x0002 for 5 cycles, then done for 1 cycle with busy=0; ch_out=0 afterward.
- Steps 0..3 dur=2, patterns 0x1,0x2,0x4,0x8, loop_start=1, loop_end=2, repeat=3, last_step=3 → step sequence 0,1,2,1,2,1,2,3 with 2 cycles each; rep_idx ends at 2; done asserted 17 cycles after start.
- Step0 dur=0 pat=0xAAAA, last_step=0 → ch_out=0xAAAA for exactly 1 cycle, then done.
- abort asserted on the 4th cycle of a dur=10 step → next edge ch_out=0, busy=0, done never asserted; a subsequent start replays from step 0.
- cfg_we writing step0 pattern=0xFFFF during RUN → run unchanged; a rerun still shows the old pattern. start held high through RUN → exactly one run per start sampled in IDLE.
- dur=2^22-1 on step0 (TW=22) → ch_out held for 4194303 cycles; scalerst asserted mid-step clears all outputs on the next edge.
